// File: rtl/lsu_mem_port.sv
// Load/store unit: turns one execute-stage access into one or two word-aligned
// bus beats with byte enables, and returns lane-aligned, extended load data.
module lsu_mem_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

    state_e      state_q, state_d;
    logic        ready_q;
    logic        write_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;
    logic [23:0] hi_q;

    logic        accept;
    logic [1:0]  off;
    logic        is_byte;
    logic        is_half;
    logic        split;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic [31:0] wdata_rot;
    logic [31:0] shifted;
    logic [31:0] ld_result;

    always_comb begin
        accept = (state_q == IDLE) && req_valid && ready_q;
    end

    // Address/size decode and lane steering, all from latched request fields.
    always_comb begin
        off     = addr_q[1:0];
        is_byte = (size_q == 2'b10);
        is_half = (size_q == 2'b01);
        split   = (is_half && (off == 2'd3)) || (!is_byte && !is_half && (off != 2'd0));

        if (is_byte)      be0 = 4'b0001 << off;
        else if (is_half) be0 = 4'b0011 << off;
        else              be0 = 4'b1111 << off;

        be1 = is_half ? 4'b0001 : (4'b1111 >> (3'd4 - {1'b0, off}));

        case (off)
            2'd0:    wdata_rot = wdata_q;
            2'd1:    wdata_rot = {wdata_q[23:0], wdata_q[31:24]};
            2'd2:    wdata_rot = {wdata_q[15:0], wdata_q[31:16]};
            default: wdata_rot = {wdata_q[7:0],  wdata_q[31:8]};
        endcase

        // Low 32 bits of {hi,lo} >> 8*off; hi only ever contributes its low 3 bytes.
        case (off)
            2'd0:    shifted = lo_q;
            2'd1:    shifted = {hi_q[7:0],  lo_q[31:8]};
            2'd2:    shifted = {hi_q[15:0], lo_q[31:16]};
            default: shifted = {hi_q[23:0], lo_q[31:24]};
        endcase

        if (write_q)      ld_result = '0;
        else if (is_byte) ld_result = {{24{signed_q & shifted[7]}}, shifted[7:0]};
        else if (is_half) ld_result = {{16{signed_q & shifted[15]}}, shifted[15:0]};
        else              ld_result = shifted;
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BEAT0;
            BEAT0:   if (mem_ack) state_d = split ? BEAT1 : RESP;
            BEAT1:   if (mem_ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        case (state_q)
            BEAT0: begin
                mem_req   = 1'b1;
                mem_we    = write_q;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = be0;
                mem_wdata = wdata_rot;
            end
            BEAT1: begin
                mem_req   = 1'b1;
                mem_we    = write_q;
                mem_addr  = {addr_q[31:2] + 30'd1, 2'b00};
                mem_be    = be1;
                mem_wdata = wdata_rot;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = ld_result;
            end
            default: ;
        endcase
    end

    // Registered ready keeps req_ready low during reset while matching state==IDLE otherwise.
    always_ff @(posedge clk) begin
        if (!reset) ready_q <= 1'b0;
        else        ready_q <= (state_d == IDLE);
    end

    assign req_ready = ready_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                signed_q <= req_signed;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                lo_q     <= '0;
                hi_q     <= '0;
            end
            if (state_q == BEAT0 && mem_ack) lo_q <= mem_rdata;
            if (state_q == BEAT1 && mem_ack) hi_q <= mem_rdata[23:0];
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: drives accesses cycle by cycle, plays the bus
// side by hand and checks every beat and response at fixed cycle positions.
module tb_lsu_mem_port;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    lsu_mem_port dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .req_signed (req_signed),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic check_beat(input string tag, input logic wr, input logic [31:0] ea,
                              input logic [3:0] ebe, input logic [31:0] ewd);
        check_eq({tag, ".req"},   {31'd0, mem_req}, 32'd1);
        check_eq({tag, ".we"},    {31'd0, mem_we}, {31'd0, wr});
        check_eq({tag, ".addr"},  mem_addr, ea);
        check_eq({tag, ".be"},    {28'd0, mem_be}, {28'd0, ebe});
        check_eq({tag, ".ready"}, {31'd0, req_ready}, 32'd0);
        check_eq({tag, ".rspv"},  {31'd0, rsp_valid}, 32'd0);
        if (wr) check_eq({tag, ".wdata"}, mem_wdata & lane_mask(ebe), ewd & lane_mask(ebe));
    endtask

    // Inputs are driven just after a falling edge; outputs are sampled there too.
    task automatic run_access(input string name, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                              input logic [31:0] rd0, input logic [31:0] rd1, input int unsigned wait0,
                              input logic [31:0] ea0, input logic [3:0] ebe0,
                              input logic two, input logic [31:0] ea1, input logic [3:0] ebe1,
                              input logic [31:0] ewd, input logic [31:0] ersp);
        check_eq({name, ".ready_pre"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        req_signed = sgn;
        mem_ack    = 1'b0;
        mem_rdata  = 32'hBAD0_BAD0;
        tick();
        req_valid  = 1'b0;
        req_addr   = 32'h5555_5555;
        req_wdata  = 32'h6666_6666;
        for (int unsigned w = 0; w < wait0; w++) begin
            check_beat({name, ".wait"}, wr, ea0, ebe0, ewd);
            tick();
        end
        check_beat({name, ".b0"}, wr, ea0, ebe0, ewd);
        mem_ack   = 1'b1;
        mem_rdata = rd0;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        if (two) begin
            check_beat({name, ".b1"}, wr, ea1, ebe1, ewd);
            mem_ack   = 1'b1;
            mem_rdata = rd1;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
        end
        check_eq({name, ".rspv"},  {31'd0, rsp_valid}, 32'd1);
        check_eq({name, ".rdata"}, rsp_rdata, ersp);
        check_eq({name, ".req_resp"}, {31'd0, mem_req}, 32'd0);
        check_eq({name, ".ready_resp"}, {31'd0, req_ready}, 32'd0);
        tick();
        check_eq({name, ".rspv_end"},  {31'd0, rsp_valid}, 32'd0);
        check_eq({name, ".ready_end"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_size   = '0;
        req_signed = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        tick();
        tick();
        check_eq("rst.ready", {31'd0, req_ready}, 32'd0);
        check_eq("rst.rspv",  {31'd0, rsp_valid}, 32'd0);
        check_eq("rst.req",   {31'd0, mem_req}, 32'd0);
        check_eq("rst.we",    {31'd0, mem_we}, 32'd0);
        check_eq("rst.addr",  mem_addr, 32'd0);
        check_eq("rst.be",    {28'd0, mem_be}, 32'd0);
        check_eq("rst.wdata", mem_wdata, 32'd0);
        check_eq("rst.rdata", rsp_rdata, 32'd0);
        reset = 1'b1;
        tick();
        check_eq("rel.ready", {31'd0, req_ready}, 32'd1);

        //         name       wr    addr           wdata          sz     sg    rd0            rd1            wt  ea0            be0      two   ea1            be1      ewd            ersp
        run_access("ld_w",    1'b0, 32'h0000_0100, 32'h0,         2'b00, 1'b0, 32'hDEAD_BEEF, 32'h0,         0, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,         4'b0000, 32'h0,         32'hDEAD_BEEF);
        run_access("ld_bs",   1'b0, 32'h0000_0103, 32'h0,         2'b10, 1'b1, 32'h8011_2233, 32'h0,         0, 32'h0000_0100, 4'b1000, 1'b0, 32'h0,         4'b0000, 32'h0,         32'hFFFF_FF80);
        run_access("ld_bu",   1'b0, 32'h0000_0103, 32'h0,         2'b10, 1'b0, 32'h8011_2233, 32'h0,         0, 32'h0000_0100, 4'b1000, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0000_0080);
        run_access("ld_hs",   1'b0, 32'h0000_0102, 32'h0,         2'b01, 1'b1, 32'h9ABC_0000, 32'h0,         0, 32'h0000_0100, 4'b1100, 1'b0, 32'h0,         4'b0000, 32'h0,         32'hFFFF_9ABC);
        run_access("ld_hu1",  1'b0, 32'h0000_0101, 32'h0,         2'b01, 1'b0, 32'hAABB_CCDD, 32'h0,         0, 32'h0000_0100, 4'b0110, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0000_BBCC);
        run_access("ld_wmis", 1'b0, 32'h0000_0201, 32'h0,         2'b00, 1'b0, 32'h4433_2211, 32'h8877_6655, 0, 32'h0000_0200, 4'b1110, 1'b1, 32'h0000_0204, 4'b0001, 32'h0,         32'h5544_3322);
        run_access("ld_hmis", 1'b0, 32'h0000_0107, 32'h0,         2'b01, 1'b1, 32'hAB00_0000, 32'h0000_00CD, 0, 32'h0000_0104, 4'b1000, 1'b1, 32'h0000_0108, 4'b0001, 32'h0,         32'hFFFF_CDAB);
        run_access("st_hwrap",1'b1, 32'hFFFF_FFFF, 32'h0000_ABCD, 2'b01, 1'b0, 32'h1234_5678, 32'h9999_9999, 0, 32'hFFFF_FFFC, 4'b1000, 1'b1, 32'h0000_0000, 4'b0001, 32'hCD00_00AB, 32'h0);
        run_access("st_b",    1'b1, 32'h0000_0401, 32'h0000_00EE, 2'b10, 1'b0, 32'h7777_7777, 32'h0,         0, 32'h0000_0400, 4'b0010, 1'b0, 32'h0,         4'b0000, 32'h0000_EE00, 32'h0);
        run_access("st_w3",   1'b1, 32'h0000_0403, 32'h1122_3344, 2'b11, 1'b0, 32'h0,         32'h0,         0, 32'h0000_0400, 4'b1000, 1'b1, 32'h0000_0404, 4'b0111, 32'h4411_2233, 32'h0);
        run_access("ld_wait", 1'b0, 32'h0000_0300, 32'h0,         2'b00, 1'b1, 32'h8234_5678, 32'h0,         3, 32'h0000_0300, 4'b1111, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h8234_5678);

        // Reset while the second beat of a split load is outstanding.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h0000_0201;
        req_size   = 2'b00;
        req_signed = 1'b0;
        tick();
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h4433_2211;
        tick();
        mem_ack = 1'b0;
        check_eq("mrst.b1req",  {31'd0, mem_req}, 32'd1);
        check_eq("mrst.b1addr", mem_addr, 32'h0000_0204);
        reset = 1'b0;
        tick();
        check_eq("mrst.req",   {31'd0, mem_req}, 32'd0);
        check_eq("mrst.ready", {31'd0, req_ready}, 32'd0);
        check_eq("mrst.rspv",  {31'd0, rsp_valid}, 32'd0);
        tick();
        check_eq("mrst.rspv2", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b1;
        tick();
        check_eq("mrst.ready_rel", {31'd0, req_ready}, 32'd1);
        check_eq("mrst.rspv_rel",  {31'd0, rsp_valid}, 32'd0);
        run_access("ld_after", 1'b0, 32'h0000_0600, 32'h0, 2'b00, 1'b0, 32'hCAFE_F00D, 32'h0, 0, 32'h0000_0600, 4'b1111, 1'b0, 32'h0, 4'b0000, 32'h0, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit sitting between the execute stage and the data-memory bus. It consumes the access-control outputs of instruction decode: `mem_read`/`mem_write`, `inst_size` (00 word, 01 half, 10 byte) and `is_signed` (1 signed, 0 unsigned), plus the ALU-computed address. It turns each access into one or two word-aligned bus transactions with byte enables. For loads it returns lane-aligned, sign- or zero-extended data. Misaligned halfword and word accesses are split into two beats in hardware, so no trap is raised.

## Interface
- No parameters; data path fixed at 32 bits, bus word-addressed with 4 byte lanes.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low
- `req_valid`  in  1  execute stage presents an access
- `req_ready`  out  1  unit can accept; a transfer occurs when `req_valid && req_ready`
- `req_write`  in  1  1 store, 0 load
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- `req_size`  in  2  00 word, 01 half, 10 byte, 11 treated as word
- `req_signed`  in  1  load extension: 1 sign, 0 zero
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  32  extended load result; 0 for stores
- `mem_req`  out  1  bus request
- `mem_we`  out  1  bus write
- `mem_addr`  out  32  word address, bits [1:0] always 0
- `mem_be`  out  4  byte enables, bit i ↔ lane [8i+7:8i]
- `mem_wdata`  out  32  lane-positioned write data
- `mem_ack`  in  1  bus completes current beat this cycle
- `mem_rdata`  in  32  read word, valid when `mem_ack`

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On transfer, latch write, addr, wdata, size and signed, then go to BEAT0.
  - `off` = `addr[1:0]`.
  - `split` is set for half with `off`=3, or word with `off`≠0.
- **Beat 0**
  - Address: `{addr[31:2],00}`.
  - Byte: `be0` = 0001<<`off`.
  - Half: `be0` = (0011<<`off`) truncated to 4 bits.
  - Word: `be0` = (1111<<`off`) truncated to 4 bits.
- **Beat 1** (only when `split`)
  - Address: `{addr[31:2]+1,00}`, mod 2^32, so 0xFFFFFFFC wraps to 0x00000000.
  - `be1` is the remaining lanes: half gives 0001; word gives 1111>>(4-`off`).
- **Write data**
  - `mem_wdata` = `req_wdata` rotated left by 8·`off`, identical on both beats.
  - Lanes outside `mem_be` are don't-care.
- **Data return**
  - On BEAT0 `mem_ack`, capture `mem_rdata` into `lo` and go to BEAT1 if `split`, else RESP.
  - On BEAT1 `mem_ack`, capture into `hi` and go to RESP.
- **Load result**
  - Form `{hi,lo}` >> 8·`off`, take bits [31:0].
  - Mask to size.
  - Sign-extend from bit 7 (byte) or 15 (half) when `signed`, else zero-extend.
  - Word ignores `signed`.
- **RESP**
  - `rsp_valid` = 1 for exactly one cycle, `rsp_rdata` valid, then return to IDLE.
  - Stores respond with `rsp_rdata` = 0.
- **Bus rule:** while `mem_req`=1, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are held stable until the `mem_ack` cycle. `mem_ack` outside BEAT0/BEAT1 is ignored.

## Timing
- Reset, while `reset`=0:
  - State goes to IDLE.
  - `req_ready`, `rsp_valid`, `mem_req`, `mem_we` = 0.
  - `mem_addr`, `mem_be`, `mem_wdata`, `rsp_rdata` = 0.
  - `req_ready` is forced to 0 during reset and rises the first cycle after release.
- All bus and response outputs are registered or decoded from the state register only, with no combinational path from `req_*` or `mem_ack` to outputs. `req_ready` is decoded from state.
- Aligned access with zero-wait bus:
  - Cycle 0: accept.
  - Cycle 1: `mem_req` high and ack.
  - Cycle 2: `rsp_valid`.
  - Latency is 2 cycles.
- Split access adds 1 cycle per beat (latency 3); each wait cycle without `mem_ack` adds 1 cycle.
- Throughput: at most one access per 3 cycles; `req_ready`=0 from accept until the cycle after RESP.
- Reset mid-access (BEAT0, BEAT1 or RESP):
  - Next edge is IDLE, `mem_req` drops.
  - No `rsp_valid` is produced; a partially written split store is not rolled back.

## Test plan
- **Aligned load:** addr 0x100, word, `mem_rdata`=0xDEADBEEF, ack in first cycle → one beat at 0x100, be 1111, `rsp_rdata`=0xDEADBEEF two cycles after accept.
- **Byte/half extension:** addr 0x103, byte, signed, rdata 0x80112233 → be 1000, result 0xFFFFFF80. Same with unsigned → 0x00000080. Half at 0x102, signed, rdata 0x9ABC0000 → 0xFFFF9ABC.
- **Misaligned word load:** addr 0x201, beat0 rdata 0x44332211 at 0x200, beat1 rdata 0x88776655 at 0x204 → be 1110 then 0001, result 0x55443322, latency 3.
- **Misaligned half store with wrap:** addr 0xFFFFFFFF, wdata 0x0000ABCD → beat0 addr 0xFFFFFFFC, be 1000, lane3=0xCD; beat1 addr 0x00000000, be 0001, lane0=0xAB; `rsp_rdata`=0.
- **Wait states:** word load with `mem_ack` delayed 3 cycles → `mem_req`, `mem_addr` and `mem_be` stable all 4 cycles, `req_ready`=0 throughout, single `rsp_valid` pulse.
- **Reset mid-split:** assert `reset`=0 during BEAT1 → `mem_req`=0 and `req_ready`=0 next cycle, no `rsp_valid`. After release, a new aligned access completes normally.
